// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - registered N-to-1 W-bit mux with direct select and auto-scan modes
module mux_scan_nto1 #(
  parameter int N     = 6,
  parameter int W     = 1,
  parameter int DWELL = 1,
  parameter int SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    din,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  output logic              sel_err,
  output logic              scan_wrap
);

  localparam int DWW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NPOW = 1 << SELW;
  localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
  localparam logic [SELW-1:0] CH_LAST = SELW'(N - 1);
  localparam logic [DWW-1:0]  DW_LAST = DWW'(DWELL - 1);

  localparam logic [0:0] ST_DIRECT = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  // Padded to a power of two so any sel value indexes a defined entry.
  logic [W-1:0] chan [NPOW];
  for (genvar k = 0; k < NPOW; k++) begin : g_chan
    if (k < N) begin : g_real
      assign chan[k] = din[k*W +: W];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  logic [0:0]      state_q, state_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [DWW-1:0]  dw_q, dw_d;
  logic [W-1:0]    out_q, out_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            wrap_q, wrap_d;

  logic [SELW-1:0] cur_ch;
  logic [DWW-1:0]  cur_dw;
  logic            sel_ok;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    dw_d     = dw_q;
    out_d    = out_q;
    out_ch_d = out_ch_q;
    valid_d  = valid_q;
    err_d    = err_q;
    wrap_d   = 1'b0;
    sel_ok   = ({1'b0, sel} < N_EXT);
    // Entering scan from direct always starts on channel 0 with a fresh dwell.
    cur_ch   = (state_q == ST_SCAN) ? ch_q : '0;
    cur_dw   = (state_q == ST_SCAN) ? dw_q : '0;

    if (en) begin
      if (!mode) begin
        state_d = ST_DIRECT;
        ch_d    = '0;
        dw_d    = '0;
        if (sel_ok) begin
          out_d    = chan[sel];
          out_ch_d = sel;
          valid_d  = 1'b1;
          err_d    = 1'b0;
        end else begin
          valid_d  = 1'b0;
          err_d    = 1'b1;
        end
      end else begin
        state_d  = ST_SCAN;
        out_d    = chan[cur_ch];
        out_ch_d = cur_ch;
        valid_d  = 1'b1;
        err_d    = 1'b0;
        if (cur_dw == DW_LAST) begin
          dw_d   = '0;
          ch_d   = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
          wrap_d = (cur_ch == CH_LAST);
        end else begin
          dw_d   = cur_dw + 1'b1;
          ch_d   = cur_ch;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_DIRECT;
      ch_q     <= '0;
      dw_q     <= '0;
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      dw_q     <= dw_d;
      out_q    <= out_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb/tb_mux_scan_nto1.sv - bench for mux_scan_nto1 (N=6/W=1/DWELL=1 and N=5/W=4/DWELL=3)
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, mode_a, en_a;
  logic [2:0] sel_a;
  logic [5:0] din_a;
  logic [0:0] out_a;
  logic [2:0] ch_a;
  logic       v_a, e_a, w_a;

  logic        rst_b, mode_b, en_b;
  logic [2:0]  sel_b;
  logic [19:0] din_b;
  logic [3:0]  out_b;
  logic [2:0]  ch_b;
  logic        v_b, e_b, w_b;

  mux_scan_nto1 #(.N(6), .W(1), .DWELL(1)) u_a (
    .clk(clk), .reset(rst_a), .din(din_a), .sel(sel_a), .mode(mode_a), .en(en_a),
    .out(out_a), .out_ch(ch_a), .out_valid(v_a), .sel_err(e_a), .scan_wrap(w_a)
  );

  mux_scan_nto1 #(.N(5), .W(4), .DWELL(3)) u_b (
    .clk(clk), .reset(rst_b), .din(din_b), .sel(sel_b), .mode(mode_b), .en(en_b),
    .out(out_b), .out_ch(ch_b), .out_valid(v_b), .sel_err(e_b), .scan_wrap(w_b)
  );

  typedef struct packed {
    logic [3:0] out;
    logic [2:0] ch;
    logic       v;
    logic       e;
    logic       w;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       mode;
    logic       en;
    logic [2:0] sel;
    logic [5:0] din;
    exp_t       exp;
    string      name;
  } vec_t;

  vec_t va[$];
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic exp_t mkexp(input logic [3:0] o, input logic [2:0] c,
                                 input logic v, input logic e, input logic w);
    exp_t x;
    x.out = o; x.ch = c; x.v = v; x.e = e; x.w = w;
    return x;
  endfunction

  function automatic vec_t mk(input logic rst, input logic mode, input logic en,
                              input logic [2:0] sel, input logic [5:0] din,
                              input exp_t x, input string name);
    vec_t r;
    r.rst = rst; r.mode = mode; r.en = en; r.sel = sel; r.din = din;
    r.exp = x; r.name = name;
    return r;
  endfunction

  task automatic compare_a(input string name);
    exp_t x;
    x = qa.pop_front();
    chk({name, ".out"},   32'(out_a), 32'(x.out));
    chk({name, ".ch"},    32'(ch_a),  32'(x.ch));
    chk({name, ".valid"}, 32'(v_a),   32'(x.v));
    chk({name, ".err"},   32'(e_a),   32'(x.e));
    chk({name, ".wrap"},  32'(w_a),   32'(x.w));
  endtask

  task automatic compare_b(input string name);
    exp_t x;
    x = qb.pop_front();
    chk({name, ".out"},   32'(out_b), 32'(x.out));
    chk({name, ".ch"},    32'(ch_b),  32'(x.ch));
    chk({name, ".valid"}, 32'(v_b),   32'(x.v));
    chk({name, ".err"},   32'(e_b),   32'(x.e));
    chk({name, ".wrap"},  32'(w_b),   32'(x.w));
  endtask

  task automatic drive_b(input logic rst, input logic mode, input logic en,
                         input logic [19:0] din, input exp_t x, input string name);
    @(negedge clk);
    rst_b = rst; mode_b = mode; en_b = en; sel_b = 3'($urandom_range(0, 7)); din_b = din;
    qb.push_back(x);
    @(posedge clk);
    #1;
    compare_b(name);
  endtask

  logic [2:0] s3_ch  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
  logic       s3_out [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [5:0]  d3;
    logic [19:0] db;
    exp_t        last_b;
    int          k;
    int          ch;
    int          wraps;

    rst_a = 1'b1; mode_a = 1'b0; en_a = 1'b0; sel_a = '0; din_a = '0;
    rst_b = 1'b1; mode_b = 1'b0; en_b = 1'b0; sel_b = '0; din_b = '0;
    d3 = 6'b100101;

    va.push_back(mk(1, 0, 1, 3, 6'b101010, mkexp(0, 0, 0, 0, 0), "rst0"));
    va.push_back(mk(1, 1, 1, 3, 6'b101010, mkexp(0, 0, 0, 0, 0), "rst1"));
    va.push_back(mk(0, 0, 1, 3, 6'b101010, mkexp(1, 3, 1, 0, 0), "dir3"));
    va.push_back(mk(0, 0, 1, 2, 6'b000100, mkexp(1, 2, 1, 0, 0), "dir2"));
    va.push_back(mk(0, 0, 1, 6, 6'b000100, mkexp(1, 2, 0, 1, 0), "sel6"));
    va.push_back(mk(0, 0, 1, 7, 6'b000001, mkexp(1, 2, 0, 1, 0), "sel7"));
    va.push_back(mk(0, 0, 1, 0, 6'b000100, mkexp(0, 0, 1, 0, 0), "sel0"));
    va.push_back(mk(0, 0, 0, 5, 6'b111111, mkexp(0, 0, 1, 0, 0), "dirhold"));
    for (int i = 0; i < 8; i++) begin
      va.push_back(mk(0, 1, 1, 7, d3,
                      mkexp(4'(s3_out[i]), s3_ch[i], 1, 0, s3_ch[i] == 3'd5),
                      $sformatf("scan%0d", i)));
      // A stall right after the wrap pulse must drop the pulse but hold everything else.
      if (i == 5)
        va.push_back(mk(0, 1, 0, 0, d3, mkexp(1, 5, 1, 0, 0), "stallwrap"));
    end
    va.push_back(mk(0, 1, 1, 0, d3, mkexp(1, 2, 1, 0, 0), "scan8"));
    va.push_back(mk(0, 1, 1, 0, d3, mkexp(0, 3, 1, 0, 0), "scan9"));
    va.push_back(mk(0, 1, 1, 0, d3, mkexp(0, 4, 1, 0, 0), "scan10"));
    va.push_back(mk(0, 0, 1, 1, d3, mkexp(0, 1, 1, 0, 0), "sw_dir"));
    va.push_back(mk(0, 1, 1, 1, d3, mkexp(1, 0, 1, 0, 0), "rescan0"));
    va.push_back(mk(0, 1, 1, 1, d3, mkexp(0, 1, 1, 0, 0), "rescan1"));
    va.push_back(mk(1, 1, 1, 1, d3, mkexp(0, 0, 0, 0, 0), "midrst"));
    va.push_back(mk(0, 1, 1, 1, d3, mkexp(1, 0, 1, 0, 0), "postrst"));

    foreach (va[i]) begin
      @(negedge clk);
      rst_a = va[i].rst; mode_a = va[i].mode; en_a = va[i].en;
      sel_a = va[i].sel; din_a = va[i].din;
      qa.push_back(va[i].exp);
      @(posedge clk);
      #1;
      compare_a(va[i].name);
    end

    // DWELL=3, N=5, W=4: each channel for 3 enabled edges, stall mid-dwell on channel 2.
    drive_b(1, 1, 1, 20'hABCDE, mkexp(0, 0, 0, 0, 0), "b_rst0");
    drive_b(1, 1, 1, 20'hABCDE, mkexp(0, 0, 0, 0, 0), "b_rst1");
    k = 0;
    wraps = 0;
    last_b = mkexp(0, 0, 0, 0, 0);
    for (int c = 0; c < 34; c++) begin
      db = 20'($urandom());
      if (c >= 7 && c < 11) begin
        last_b.w = 1'b0;
        drive_b(0, 1, 0, db, last_b, $sformatf("b_stall%0d", c));
      end else begin
        ch = (k / 3) % 5;
        last_b = mkexp(db[ch*4 +: 4], 3'(ch), 1, 0, (k % 15) == 14);
        k++;
        drive_b(0, 1, 1, db, last_b, $sformatf("b_scan%0d", c));
      end
      if (w_b) wraps++;
    end
    chk("b_wrap_count", 32'(wraps), 32'd2);

    // Mid-scan reset on the wide instance, then scan restarts at channel 0.
    drive_b(1, 1, 1, 20'h12345, mkexp(0, 0, 0, 0, 0), "b_midrst");
    drive_b(0, 1, 1, 20'h12345, mkexp(4'h5, 0, 1, 0, 0), "b_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
